// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: Zicsr funct3 encodings and CSR addresses.
package csr_pkg;

  typedef enum logic [2:0] {
    CSR_NONE0 = 3'b000,
    CSR_RW    = 3'b001,
    CSR_RS    = 3'b010,
    CSR_RC    = 3'b011,
    CSR_NONE4 = 3'b100,
    CSR_RWI   = 3'b101,
    CSR_RSI   = 3'b110,
    CSR_RCI   = 3'b111
  } csr_op_e;

  localparam logic [11:0] MIE_ADDR      = 12'h304;
  localparam logic [11:0] MTVEC_ADDR    = 12'h305;
  localparam logic [11:0] MSCRATCH_ADDR = 12'h340;
  localparam logic [11:0] MEPC_ADDR     = 12'h341;
  localparam logic [11:0] MCAUSE_ADDR   = 12'h342;

endpackage

// File: rtl/csr_controller.sv
// Machine-mode CSR file: mie, mtvec, mscratch, mepc, mcause with Zicsr read-modify-write
// and trap capture of the faulting PC and cause.
module csr_controller
  import csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trap_i,
  input  logic [2:0]  opcode_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] imm_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic [31:0] mie_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtvec_o
);

  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] wdata;
  logic        mie_we, mtvec_we, mscratch_we, mepc_we, mcause_we;

  always_comb begin
    read_data_o = 32'h0;
    case (addr_i)
      MIE_ADDR:      read_data_o = mie_q;
      MTVEC_ADDR:    read_data_o = mtvec_q;
      MSCRATCH_ADDR: read_data_o = mscratch_q;
      MEPC_ADDR:     read_data_o = mepc_q;
      MCAUSE_ADDR:   read_data_o = mcause_q;
      default:       read_data_o = 32'h0;
    endcase
  end

  // Read-modify-write operates on the pre-edge value; unlisted funct3 codes rewrite the old value.
  always_comb begin
    wdata = read_data_o;
    case (opcode_i)
      CSR_RW:  wdata = rs1_data_i;
      CSR_RS:  wdata = rs1_data_i | read_data_o;
      CSR_RC:  wdata = ~rs1_data_i & read_data_o;
      CSR_RWI: wdata = imm_data_i;
      CSR_RSI: wdata = imm_data_i | read_data_o;
      CSR_RCI: wdata = ~imm_data_i & read_data_o;
      default: wdata = read_data_o;
    endcase
  end

  assign mie_we      = write_enable_i && (addr_i == MIE_ADDR);
  assign mtvec_we    = write_enable_i && (addr_i == MTVEC_ADDR);
  assign mscratch_we = write_enable_i && (addr_i == MSCRATCH_ADDR);
  assign mepc_we     = write_enable_i && (addr_i == MEPC_ADDR);
  assign mcause_we   = write_enable_i && (addr_i == MCAUSE_ADDR);

  // Trap capture is applied after the CSR write so it wins on mepc/mcause.
  always_comb begin
    mie_d      = mie_we      ? wdata : mie_q;
    mtvec_d    = mtvec_we    ? wdata : mtvec_q;
    mscratch_d = mscratch_we ? wdata : mscratch_q;
    mepc_d     = mepc_we     ? wdata : mepc_q;
    mcause_d   = mcause_we   ? wdata : mcause_q;
    if (trap_i) begin
      mepc_d   = pc_i;
      mcause_d = mcause_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= 32'h0;
      mtvec_q    <= 32'h0;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else begin
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign mie_o   = mie_q;
  assign mepc_o  = mepc_q;
  assign mtvec_o = mtvec_q;

endmodule

// File: tb/tb_csr_controller.sv
// Directed self-checking bench for csr_controller: Zicsr ops, trap capture, collisions and reset.
module tb_csr_controller;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        trap_i = 1'b0;
  logic [2:0]  opcode_i = 3'b000;
  logic [11:0] addr_i = 12'h000;
  logic [31:0] pc_i = 32'h0;
  logic [31:0] mcause_i = 32'h0;
  logic [31:0] rs1_data_i = 32'h0;
  logic [31:0] imm_data_i = 32'h0;
  logic        write_enable_i = 1'b0;
  logic [31:0] read_data_o, mie_o, mepc_o, mtvec_o;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [11:0] ADDRS [5] = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342};

  csr_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .trap_i         (trap_i),
    .opcode_i       (opcode_i),
    .addr_i         (addr_i),
    .pc_i           (pc_i),
    .mcause_i       (mcause_i),
    .rs1_data_i     (rs1_data_i),
    .imm_data_i     (imm_data_i),
    .write_enable_i (write_enable_i),
    .read_data_o    (read_data_o),
    .mie_o          (mie_o),
    .mepc_o         (mepc_o),
    .mtvec_o        (mtvec_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One committed CSR op; inputs are released one time unit after the edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] rs1, input logic [31:0] imm);
    opcode_i = op;
    addr_i = addr;
    rs1_data_i = rs1;
    imm_data_i = imm;
    write_enable_i = 1'b1;
    tick();
    write_enable_i = 1'b0;
    trap_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks += 3;
    if (mie_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mie got %h want %h", mie_o, 32'h0); end
    if (mepc_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mepc got %h want %h", mepc_o, 32'h0); end
    if (mtvec_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mtvec got %h want %h", mtvec_o, 32'h0); end
    for (int i = 0; i < 5; i++) begin
      addr_i = ADDRS[i];
      #1;
      n_checks++;
      if (read_data_o !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_read addr %h got %h want %h", ADDRS[i], read_data_o, 32'h0);
      end
    end
  endtask

  task automatic test_rw();
    logic [31:0] exp_val [5];
    apply_stimulus(3'b001, 12'h305, 32'h1234_5678, 32'h0);
    n_checks++;
    if (mtvec_o !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL rw_mtvec_o got %h want %h", mtvec_o, 32'h1234_5678); end
    exp_val = '{32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      addr_i = ADDRS[i];
      #1;
      n_checks++;
      if (read_data_o !== exp_val[i]) begin
        n_fail++;
        $display("[TB] FAIL rw_read addr %h got %h want %h", ADDRS[i], read_data_o, exp_val[i]);
      end
    end
  endtask

  task automatic test_set_clear();
    apply_stimulus(3'b001, 12'h340, 32'h0F0F_0000, 32'hFFFF_FFFF);
    apply_stimulus(3'b010, 12'h340, 32'h0000_00FF, 32'h0);
    addr_i = 12'h340; #1;
    n_checks++;
    if (read_data_o !== 32'h0F0F_00FF) begin n_fail++; $display("[TB] FAIL rs_mscratch got %h want %h", read_data_o, 32'h0F0F_00FF); end
    apply_stimulus(3'b011, 12'h340, 32'h0F00_000F, 32'h0);
    addr_i = 12'h340; #1;
    n_checks++;
    if (read_data_o !== 32'h000F_00F0) begin n_fail++; $display("[TB] FAIL rc_mscratch got %h want %h", read_data_o, 32'h000F_00F0); end
  endtask

  task automatic test_imm();
    apply_stimulus(3'b101, 12'h304, 32'hFFFF_FFFF, 32'h0000_001F);
    n_checks++;
    if (mie_o !== 32'h1F) begin n_fail++; $display("[TB] FAIL rwi_mie got %h want %h", mie_o, 32'h1F); end
    apply_stimulus(3'b110, 12'h304, 32'h0000_0100, 32'h0000_0020);
    n_checks++;
    if (mie_o !== 32'h3F) begin n_fail++; $display("[TB] FAIL rsi_mie got %h want %h", mie_o, 32'h3F); end
    apply_stimulus(3'b111, 12'h304, 32'h0000_003E, 32'h0000_0001);
    n_checks++;
    if (mie_o !== 32'h3E) begin n_fail++; $display("[TB] FAIL rci_mie got %h want %h", mie_o, 32'h3E); end
    // csrr form and the two unused funct3 codes must leave mie untouched
    apply_stimulus(3'b010, 12'h304, 32'h0, 32'hFFFF_FFFF);
    apply_stimulus(3'b000, 12'h304, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply_stimulus(3'b100, 12'h304, 32'h0, 32'h0);
    n_checks++;
    if (mie_o !== 32'h3E) begin n_fail++; $display("[TB] FAIL nochange_mie got %h want %h", mie_o, 32'h3E); end
  endtask

  task automatic test_trap();
    trap_i = 1'b1;
    pc_i = 32'h8000_0100;
    mcause_i = 32'h8000_000B;
    opcode_i = 3'b011;
    addr_i = 12'h305;
    rs1_data_i = 32'hFFFF_FFFF;
    write_enable_i = 1'b0;
    tick();
    trap_i = 1'b0;
    n_checks += 2;
    if (mepc_o !== 32'h8000_0100) begin n_fail++; $display("[TB] FAIL trap_mepc got %h want %h", mepc_o, 32'h8000_0100); end
    if (mtvec_o !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL trap_mtvec got %h want %h", mtvec_o, 32'h1234_5678); end
    addr_i = 12'h342; #1;
    n_checks++;
    if (read_data_o !== 32'h8000_000B) begin n_fail++; $display("[TB] FAIL trap_mcause got %h want %h", read_data_o, 32'h8000_000B); end
  endtask

  task automatic test_trap_collision();
    trap_i = 1'b1;
    pc_i = 32'hAAAA_0000;
    mcause_i = 32'h0000_0007;
    apply_stimulus(3'b001, 12'h341, 32'h0000_5555, 32'h0);
    n_checks++;
    if (mepc_o !== 32'hAAAA_0000) begin n_fail++; $display("[TB] FAIL coll_mepc got %h want %h", mepc_o, 32'hAAAA_0000); end
    trap_i = 1'b1;
    pc_i = 32'hBBBB_0004;
    mcause_i = 32'h0000_0003;
    apply_stimulus(3'b001, 12'h342, 32'h0000_5555, 32'h0);
    addr_i = 12'h342; #1;
    n_checks++;
    if (read_data_o !== 32'h3) begin n_fail++; $display("[TB] FAIL coll_mcause got %h want %h", read_data_o, 32'h3); end
    trap_i = 1'b1;
    pc_i = 32'hCCCC_0008;
    mcause_i = 32'h0000_0002;
    apply_stimulus(3'b001, 12'h304, 32'h0000_0008, 32'h0);
    n_checks += 2;
    if (mie_o !== 32'h8) begin n_fail++; $display("[TB] FAIL coll_mie got %h want %h", mie_o, 32'h8); end
    if (mepc_o !== 32'hCCCC_0008) begin n_fail++; $display("[TB] FAIL coll_mepc2 got %h want %h", mepc_o, 32'hCCCC_0008); end
  endtask

  task automatic test_ignored_writes();
    logic [31:0] exp_val [5];
    apply_stimulus(3'b001, 12'h300, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    addr_i = 12'h300; #1;
    n_checks++;
    if (read_data_o !== 32'h0) begin n_fail++; $display("[TB] FAIL unk_addr_read got %h want %h", read_data_o, 32'h0); end
    opcode_i = 3'b001;
    addr_i = 12'h305;
    rs1_data_i = 32'hFFFF_0000;
    write_enable_i = 1'b0;
    tick();
    exp_val = '{32'h8, 32'h1234_5678, 32'h000F_00F0, 32'hCCCC_0008, 32'h2};
    for (int i = 0; i < 5; i++) begin
      addr_i = ADDRS[i];
      #1;
      n_checks++;
      if (read_data_o !== exp_val[i]) begin
        n_fail++;
        $display("[TB] FAIL ignored_read addr %h got %h want %h", ADDRS[i], read_data_o, exp_val[i]);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    apply_stimulus(3'b001, 12'h304, 32'h1111_1111, 32'h0);
    apply_stimulus(3'b001, 12'h305, 32'h2222_2222, 32'h0);
    apply_stimulus(3'b001, 12'h340, 32'h3333_3333, 32'h0);
    apply_stimulus(3'b001, 12'h341, 32'h4444_4444, 32'h0);
    apply_stimulus(3'b001, 12'h342, 32'h5555_5555, 32'h0);
    addr_i = 12'h342; #1;
    n_checks++;
    if (read_data_o !== 32'h5555_5555) begin n_fail++; $display("[TB] FAIL pre_reset_mcause got %h want %h", read_data_o, 32'h5555_5555); end
    rst_i = 1'b1;
    trap_i = 1'b1;
    pc_i = 32'h9999_9999;
    mcause_i = 32'h9999_9999;
    opcode_i = 3'b001;
    addr_i = 12'h304;
    rs1_data_i = 32'hFFFF_FFFF;
    write_enable_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    trap_i = 1'b0;
    write_enable_i = 1'b0;
    n_checks += 3;
    if (mie_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rst2_mie got %h want %h", mie_o, 32'h0); end
    if (mepc_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rst2_mepc got %h want %h", mepc_o, 32'h0); end
    if (mtvec_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rst2_mtvec got %h want %h", mtvec_o, 32'h0); end
    for (int i = 0; i < 5; i++) begin
      addr_i = ADDRS[i];
      #1;
      n_checks++;
      if (read_data_o !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL rst2_read addr %h got %h want %h", ADDRS[i], read_data_o, 32'h0);
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_rw();
    test_set_clear();
    test_imm();
    test_trap();
    test_trap_collision();
    test_ignored_writes();
    test_back_to_back_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_controller.md
Name: csr_controller

Overview:
- Machine-mode CSR register file and read-modify-write unit for the RISC-V core.
- Holds mie, mtvec, mscratch, mepc and mcause.
- Executes the six Zicsr operations selected by funct3 on the addressed register.
- Captures the trap PC and cause on trap entry; exports mie, mepc and mtvec to the interrupt/trap logic and PC mux.

Parameters:
- none (all constants come from csr_pkg)

Ports:
- clk_i  input  1  system clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous and active-high; one clock
- trap_i  input  1  trap-entry strobe; load mepc and mcause this edge
- opcode_i  input  3  CSR operation (funct3 encoding, csr_pkg)
- addr_i  input  12  CSR address
- pc_i  input  32  PC of trapping instruction, saved to mepc on trap
- mcause_i  input  32  trap cause, saved to mcause on trap
- rs1_data_i  input  32  register operand for CSR_RW/RS/RC
- imm_data_i  input  32  immediate operand for CSR_RWI/RSI/RCI, already zero-extended upstream; used as-is
- write_enable_i  input  1  commit CSR operation this edge
- read_data_o  output  32  current value of CSR at addr_i (combinational)
- mie_o  output  32  mie register
- mepc_o  output  32  mepc register
- mtvec_o  output  32  mtvec register

Behaviour:
- Registers: mie, mtvec, mscratch, mepc, mcause, all 32 bit.
- Reset: on a rising edge with rst_i=1, all five registers are cleared to 0. Reset overrides trap and writes. All outputs read 0 the cycle after reset.
- Read path: read_data_o is a combinational mux of the register at addr_i with zero latency.
  - 0x304 → mie; 0x305 → mtvec; 0x340 → mscratch; 0x341 → mepc; 0x342 → mcause.
  - Any other address → 0.
- Write data (combinational, old = read_data_o):
  - CSR_RW: rs1
  - CSR_RS: rs1 | old
  - CSR_RC: ~rs1 & old
  - CSR_RWI: imm
  - CSR_RSI: imm | old
  - CSR_RCI: ~imm & old
  - Any other opcode: old (no change).
- Write: on a rising edge with write_enable_i=1 and rst_i=0, the register selected by addr_i takes the write data. The new value is visible on read_data_o and the matching output the following cycle.
  - Unknown address: write ignored.
  - write_enable_i=0: no CSR changes from addr/opcode.
- Trap: on a rising edge with trap_i=1, mepc ← pc_i and mcause ← mcause_i, regardless of opcode_i and addr_i.
- Simultaneous trap and write to mepc or mcause: trap value wins.
- Simultaneous trap and write to mie, mtvec or mscratch: that write still commits.
- CSR_RS/RSI with an all-zero operand (csrr form) leaves the register unchanged; no special-casing is needed.
- mie_o, mepc_o and mtvec_o are direct register outputs, always valid, not gated by addr_i.
- No handshake; one operation per cycle; the read-modify-write uses the pre-edge value.

Decomposition:
- csr_pkg holds:
  - opcode constants: CSR_RW=3'b001, CSR_RS=3'b010, CSR_RC=3'b011, CSR_RWI=3'b101, CSR_RSI=3'b110, CSR_RCI=3'b111
  - address constants: MIE_ADDR=12'h304, MTVEC_ADDR=12'h305, MSCRATCH_ADDR=12'h340, MEPC_ADDR=12'h341, MCAUSE_ADDR=12'h342
- Single flat module; no sub-module. The write-data ALU is one always_comb block, and each register has its own enable decode.

Test Plan:
- Reset, then CSR_RW addr 0x305 rs1=0x1234_5678, we=1 for one cycle → next cycle mtvec_o and read_data_o (addr 0x305) = 0x1234_5678; other CSRs remain 0.
- mscratch=0x0F0F_0000, then CSR_RS rs1=0x0000_00FF → 0x0F0F_00FF; then CSR_RC rs1=0x0F00_000F → 0x000F_00F0.
- mie=0, then CSR_RWI imm=0x1F → mie_o=0x1F; CSR_RSI imm=0x20 → 0x3F; CSR_RCI imm=0x01 → 0x3E. Same ops with rs1≠imm confirm the I-forms use imm.
- trap_i=1 with pc_i=0x8000_0100, mcause_i=0x8000_000B, opcode_i random, we=0 → next cycle mepc_o=0x8000_0100; read_data_o at 0x342 = 0x8000_000B.
- Same edge: trap with pc_i=0xAAAA_0000 and CSR_RW to 0x341 rs1=0x5555 → mepc_o=0xAAAA_0000. Same edge: trap and CSR_RW to 0x304 rs1=0x8 → mie_o=0x8 and mepc updated.
- Write 0xDEAD_BEEF to address 0x300 → no register changes; read_data_o=0. Assert rst_i for 2 cycles after writing all five CSRs → every CSR reads 0.
